// File: rtl/corefifo_wr_gray_ptr_pkg.sv
// Shared constants and types for the FIFO write-side Gray pointer block.
package corefifo_wr_gray_ptr_pkg;

    localparam int ADDRWIDTH_DEF = 3;
    localparam int PTR_W_DEF     = ADDRWIDTH_DEF + 1;
    localparam int DEPTH_DEF     = 1 << ADDRWIDTH_DEF;
    localparam int AFULL_DEF     = 6;

    typedef struct packed {
        logic full;
        logic afull;
        logic ack;
        logic ovf;
    } wr_flags_t;

endpackage

// File: rtl/corefifo_wr_gray_ptr_if.sv
// Write-side bus: request and synced read pointer in, RAM strobe and status out.
interface corefifo_wr_gray_ptr_if
    import corefifo_wr_gray_ptr_pkg::*;
#(
    parameter int ADDRWIDTH = ADDRWIDTH_DEF
);

    logic                 we;
    logic [ADDRWIDTH:0]   rd_ptr_gray_sync;
    logic [ADDRWIDTH-1:0] wr_addr;
    logic [ADDRWIDTH:0]   wr_ptr_gray;
    logic                 wr_en_ram;
    logic                 full;
    logic                 afull;
    logic                 wr_ack;
    logic                 overflow;
    logic [ADDRWIDTH:0]   wr_count;

    modport master (
        output we, rd_ptr_gray_sync,
        input  wr_addr, wr_ptr_gray, wr_en_ram, full,
        input  afull, wr_ack, overflow, wr_count
    );

    modport slave (
        input  we, rd_ptr_gray_sync,
        output wr_addr, wr_ptr_gray, wr_en_ram, full,
        output afull, wr_ack, overflow, wr_count
    );

endinterface

// File: rtl/corefifo_wr_gray_ptr_gray2bin.sv
// Combinational Gray-to-binary decoder: bit i is the XOR of Gray bits i..MSB.
module corefifo_wr_gray_ptr_gray2bin
    import corefifo_wr_gray_ptr_pkg::*;
#(
    parameter int ADDRWIDTH = ADDRWIDTH_DEF
) (
    input  logic [ADDRWIDTH:0] gray_i,
    output logic [ADDRWIDTH:0] bin_o
);

    for (genvar i = 0; i <= ADDRWIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[ADDRWIDTH:i];
    end

endmodule

// File: rtl/corefifo_wr_gray_ptr.sv
// Write-domain pointer of an async FIFO: binary/Gray pointer, full/afull,
// occupancy, ack and overflow pulses, all registered on the same edge.
module corefifo_wr_gray_ptr
    import corefifo_wr_gray_ptr_pkg::*;
#(
    parameter int ADDRWIDTH = ADDRWIDTH_DEF,
    parameter int AFULL_VAL = AFULL_DEF
) (
    input logic                   clk,
    input logic                   reset,
    corefifo_wr_gray_ptr_if.slave wr
);

    localparam int PW = ADDRWIDTH + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_cmp;
    wr_flags_t     flags_q, flags_d;
    logic          accept;

    corefifo_wr_gray_ptr_gray2bin #(
        .ADDRWIDTH (ADDRWIDTH)
    ) ptr_gray2bin (
        .gray_i (wr.rd_ptr_gray_sync),
        .bin_o  (rbin)
    );

    assign accept = wr.we & ~flags_q.full;

    // Full when our next Gray pointer is one lap ahead of the read pointer:
    // in Gray code that is the read pointer with its top two bits inverted.
    assign full_cmp = {~wr.rd_ptr_gray_sync[ADDRWIDTH:ADDRWIDTH-1],
                       wr.rd_ptr_gray_sync[ADDRWIDTH-2:0]};

    always_comb begin
        wbin_d        = wbin_q + PW'(accept);
        gray_d        = wbin_d ^ (wbin_d >> 1);
        cnt_d         = wbin_d - rbin;
        flags_d.full  = (gray_d == full_cmp);
        flags_d.afull = (int'(cnt_d) >= AFULL_VAL);
        flags_d.ack   = accept;
        flags_d.ovf   = wr.we & flags_q.full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbin_q  <= '0;
            gray_q  <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            wbin_q  <= wbin_d;
            gray_q  <= gray_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end

    assign wr.wr_en_ram   = accept;
    assign wr.wr_addr     = wbin_q[ADDRWIDTH-1:0];
    assign wr.wr_ptr_gray = gray_q;
    assign wr.wr_count    = cnt_q;
    assign wr.full        = flags_q.full;
    assign wr.afull       = flags_q.afull;
    assign wr.wr_ack      = flags_q.ack;
    assign wr.overflow    = flags_q.ovf;

endmodule

// File: tb/tb_corefifo_wr_gray_ptr.sv
// Scoreboard bench for the write-side Gray pointer (ADDRWIDTH=3, AFULL_VAL=6).
module tb_corefifo_wr_gray_ptr;
    import corefifo_wr_gray_ptr_pkg::*;

    typedef struct {
        int gray;
        int addr;
        int cnt;
        bit full;
        bit afull;
        bit ack;
        bit ovf;
        bit wren;
        bit onebit;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t q[$];

    // model state
    int wb;
    int rb;
    bit full_m;

    corefifo_wr_gray_ptr_if #(.ADDRWIDTH(ADDRWIDTH_DEF)) bus ();

    corefifo_wr_gray_ptr #(
        .ADDRWIDTH (ADDRWIDTH_DEF),
        .AFULL_VAL (AFULL_DEF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wr    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int g(input int b);
        return (b ^ (b >> 1)) & (2 * DEPTH_DEF - 1);
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic step(input bit rst, input bit we_v, input int rb_new,
                        input bit onebit = 1'b0, input int hand_gray = -1);
        exp_t e;
        int   cnt;
        bit   acc;
        reset = rst;
        bus.we = we_v;
        rb = rb_new & (2 * DEPTH_DEF - 1);
        bus.rd_ptr_gray_sync = PTR_W_DEF'(g(rb));
        if (rst) begin
            wb = 0;
            full_m = 1'b0;
            e.cnt = 0;
            e.afull = 1'b0;
            e.ack = 1'b0;
            e.ovf = 1'b0;
        end else begin
            acc = we_v && !full_m;
            e.ovf = we_v && full_m;
            e.ack = acc;
            if (acc) wb = (wb + 1) % (2 * DEPTH_DEF);
            cnt = (wb - rb + 2 * DEPTH_DEF) % (2 * DEPTH_DEF);
            full_m = (cnt == DEPTH_DEF);
            e.cnt = cnt;
            e.afull = (cnt >= AFULL_DEF);
        end
        e.full = full_m;
        e.gray = (hand_gray >= 0) ? hand_gray : g(wb);
        e.addr = wb % DEPTH_DEF;
        e.wren = we_v && !full_m;
        e.onebit = onebit;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: each edge the DUT presents a fresh state; pop and compare.
    initial begin
        exp_t e;
        logic [PTR_W_DEF-1:0] prev;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr_ptr_gray", int'(bus.wr_ptr_gray), e.gray);
                chk("wr_addr", int'(bus.wr_addr), e.addr);
                chk("wr_count", int'(bus.wr_count), e.cnt);
                chk("full", int'(bus.full), int'(e.full));
                chk("afull", int'(bus.afull), int'(e.afull));
                chk("wr_ack", int'(bus.wr_ack), int'(e.ack));
                chk("overflow", int'(bus.overflow), int'(e.ovf));
                chk("wr_en_ram", int'(bus.wr_en_ram), int'(e.wren));
                if (e.onebit)
                    chk("gray_onebit", $countones(bus.wr_ptr_gray ^ prev) > 1, 0);
                prev = bus.wr_ptr_gray;
            end
        end
    end

    initial begin
        int hand33[8];
        total = 0;
        bad = 0;
        wb = 0;
        rb = 0;
        full_m = 1'b0;
        hand33 = '{'h1, 'h3, 'h2, 'h6, 'h7, 'h5, 'h4, 'hC};

        // reset held 3 cycles with a write request pending
        repeat (3) step(1'b1, 1'b1, 0);

        // fill: hand-computed Gray sequence
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 0, 1'b0, hand33[i]);

        // write while full, then idle while still full
        step(1'b0, 1'b1, 0, 1'b0, 'hC);
        step(1'b0, 1'b0, 0, 1'b0, 'hC);

        // read advances: full drops, next write lands at Gray D
        step(1'b0, 1'b0, 1, 1'b0, 'hC);
        step(1'b0, 1'b1, 1, 1'b0, 'hD);

        // read catches up to 4 behind, then 16 writes through a wrap
        for (int r = 2; r <= 5; r++) step(1'b0, 1'b0, r);
        for (int k = 0; k < 16; k++) step(1'b0, 1'b1, wb - 4, 1'b1);

        // reset mid-operation after 5 writes
        step(1'b1, 1'b0, 0);
        repeat (5) step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 0, 1'b0, 'h1);
        step(1'b0, 1'b0, 0);

        for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/corefifo_wr_gray_ptr.md
CORefifo_wr_gray_ptr -- requirements

Correction on line 1 heading, as stated below:

COREFIFO_WR_GRAY_PTR -- requirements
Module: corefifo_wr_gray_ptr

Interface
REQ-001 Parameter ADDRWIDTH, default 3, FIFO address width; depth = 2^ADDRWIDTH, pointers ADDRWIDTH+1 bits.
REQ-002 Parameter AFULL_VAL, default 6, almost-full threshold in words (1 to 2^ADDRWIDTH).
REQ-003 clk  input  1  single write-domain clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 we  input  1  write request.
REQ-006 rd_ptr_gray_sync  input  ADDRWIDTH+1  read pointer, Gray-coded, already synchronized into clk domain.
REQ-007 wr_addr  output  ADDRWIDTH  binary RAM write address (low bits of binary pointer).
REQ-008 wr_ptr_gray  output  ADDRWIDTH+1  registered Gray write pointer for crossing to read domain.
REQ-009 wr_en_ram  output  1  combinational RAM write strobe = we AND NOT full.
REQ-010 full  output  1  registered full flag.
REQ-011 afull  output  1  registered almost-full flag.
REQ-012 wr_ack  output  1  one-cycle pulse, cycle after an accepted write.
REQ-013 overflow  output  1  one-cycle pulse, cycle after a write attempted while full.
REQ-014 wr_count  output  ADDRWIDTH+1  registered occupancy seen from write side.

Function
REQ-015 Accepted write = we AND NOT full; binary pointer wbin increments by 1 modulo 2^(ADDRWIDTH+1) per accepted write, else holds.
REQ-016 wr_ptr_gray shall be registered from wbin_next XOR (wbin_next >> 1) in the same edge as wbin; no combinational path from wbin to wr_ptr_gray output.
REQ-017 wr_ptr_gray shall change at most one bit per clock.
REQ-018 full_next = (gray_next == {~rd_ptr_gray_sync[ADDRWIDTH:ADDRWIDTH-1], rd_ptr_gray_sync[ADDRWIDTH-2:0]}); full registered from full_next.
REQ-019 rbin = Gray-to-binary of rd_ptr_gray_sync; wr_count registered from (wbin_next - rbin) modulo 2^(ADDRWIDTH+1).
REQ-020 afull registered from (wbin_next - rbin) >= AFULL_VAL.
REQ-021 Latency: accepted write at edge N -> wr_ptr_gray, wr_addr, full, afull, wr_count, wr_ack updated at edge N.
REQ-022 Write while full: pointer, wr_addr, count unchanged; overflow=1 for one cycle; wr_ack=0.
REQ-023 Full deasserts the cycle after rd_ptr_gray_sync advances (one-edge registered reaction), even without a write.
REQ-024 Pointer wrap from 2^(ADDRWIDTH+1)-1 to 0 seamless; Gray MSB toggles once per full traversal.
REQ-025 Count never exceeds 2^ADDRWIDTH given a legal synchronized read pointer; behaviour with illegal read pointer undefined.

Reset
REQ-026 reset asserted: wbin, wr_addr, wr_ptr_gray, wr_count = 0; full, afull, wr_ack, overflow = 0 on next edge.
REQ-027 reset has priority over we in the same cycle; a write presented during reset is dropped, no ack, no overflow.
REQ-028 Reset mid-operation returns all outputs to reset values regardless of rd_ptr_gray_sync; the read side is reset concurrently by system contract.

Structure
REQ-029 Shared package holds ADDRWIDTH default, pointer width constant (ADDRWIDTH+1) and depth constant.
REQ-030 One sub-module: ptr_gray2bin, instance of the team's combinational gray-to-binary converter parameterized by ADDRWIDTH, decoding rd_ptr_gray_sync.
REQ-031 Binary-to-Gray encode stays inline; no other hierarchy.

Verification (ADDRWIDTH=3, AFULL_VAL=6)
REQ-032 Reset held 3 cycles with we=1 -> all outputs 0, no wr_ack.
REQ-033 8 consecutive writes, rd_ptr_gray_sync=0 -> wr_ptr_gray 1,3,2,6,7,5,4,C; afull rises after 6th write; full=1 and wr_count=8 after 8th.
REQ-034 Write at full -> overflow one-cycle pulse, wr_ptr_gray stays C, wr_addr stays 0.
REQ-035 From full, rd_ptr_gray_sync 0->1 -> full=0, wr_count=7 next edge; following write accepted, wr_ptr_gray=D.
REQ-036 16 writes with read pointer tracking 4 behind -> wbin wraps F->0, wr_ptr_gray 8->0, full never asserted, single-bit change every edge checked.
REQ-037 Reset asserted after 5 writes -> next edge all outputs 0; subsequent write yields wr_ptr_gray=1.
